// File: rtl/host_decoupled_bridge_if.sv
// Signal bundle between host endpoints, the emulator's decoupled ports and the bridge.
// master = host/emulator side, slave = bridge side.
interface host_decoupled_bridge_if #(
  parameter int HOST_W    = 16,
  parameter int IN_WORDS  = 2,
  parameter int OUT_WORDS = 1
);
  logic [IN_WORDS*HOST_W-1:0]  host_in_words;
  logic                        host_in_toggle;
  logic                        host_in_ack;
  logic                        deq_valid;
  logic                        deq_ready;
  logic [IN_WORDS*HOST_W-1:0]  deq_bits;
  logic                        enq_valid;
  logic                        enq_ready;
  logic [OUT_WORDS*HOST_W-1:0] enq_bits;
  logic [OUT_WORDS*HOST_W-1:0] host_out_words;
  logic                        host_out_toggle;
  logic                        host_out_ack;
  logic [15:0]                 in_count;
  logic [15:0]                 out_count;

  modport master (
    output host_in_words, host_in_toggle, deq_ready, enq_valid, enq_bits, host_out_ack,
    input  host_in_ack, deq_valid, deq_bits, enq_ready, host_out_words, host_out_toggle,
           in_count, out_count
  );

  modport slave (
    input  host_in_words, host_in_toggle, deq_ready, enq_valid, enq_bits, host_out_ack,
    output host_in_ack, deq_valid, deq_bits, enq_ready, host_out_words, host_out_toggle,
           in_count, out_count
  );
endinterface

// File: rtl/host_decoupled_bridge.sv
// Toggle-handshake bridge between host wire endpoints and emulator ready/valid ports.
// One host toggle commit yields exactly one transfer in each direction.
//
// state   | meaning
// I_IDLE  | no ingress payload held; waiting for host toggle to differ from ack
// I_HOLD  | ingress payload presented on deq_bits with deq_valid=1
// E_EMPTY | egress holding register free; enq_ready=1
// E_FULL  | egress payload held for host; waiting for host ack to match toggle
module host_decoupled_bridge #(
  parameter int HOST_W      = 16,
  parameter int IN_WORDS    = 2,
  parameter int OUT_WORDS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clock,
  input logic                 reset,
  host_decoupled_bridge_if.slave bus
);
  typedef enum logic {I_IDLE, I_HOLD} in_state_t;
  typedef enum logic {E_EMPTY, E_FULL} out_state_t;

  in_state_t                   in_state;
  out_state_t                  out_state;
  logic [SYNC_STAGES-1:0]      tin_sync;
  logic [SYNC_STAGES-1:0]      oack_sync;
  logic                        tin_s;
  logic                        oack_s;
  logic [IN_WORDS*HOST_W-1:0]  deq_bits_q;
  logic                        in_ack_q;
  logic [15:0]                 in_cnt;
  logic                        enq_ready_q;
  logic [OUT_WORDS*HOST_W-1:0] out_words_q;
  logic                        out_tog_q;
  logic [15:0]                 out_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      tin_sync  <= '0;
      oack_sync <= '0;
    end else begin
      tin_sync  <= {tin_sync[SYNC_STAGES-2:0], bus.host_in_toggle};
      oack_sync <= {oack_sync[SYNC_STAGES-2:0], bus.host_out_ack};
    end
  end

  assign tin_s  = tin_sync[SYNC_STAGES-1];
  assign oack_s = oack_sync[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      in_state   <= I_IDLE;
      deq_bits_q <= '0;
      in_ack_q   <= 1'b0;
      in_cnt     <= '0;
    end else begin
      unique case (in_state)
        I_IDLE: begin
          if (tin_s != in_ack_q) begin
            deq_bits_q <= bus.host_in_words;
            in_state   <= I_HOLD;
          end
        end
        I_HOLD: begin
          if (bus.deq_ready) begin
            in_ack_q <= ~in_ack_q;
            in_cnt   <= in_cnt + 16'd1;
            in_state <= I_IDLE;
          end
        end
      endcase
    end
  end

  // enq_ready is a separate flop so it stays low for the cycle right after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      out_state   <= E_EMPTY;
      enq_ready_q <= 1'b0;
      out_words_q <= '0;
      out_tog_q   <= 1'b0;
      out_cnt     <= '0;
    end else begin
      unique case (out_state)
        E_EMPTY: begin
          if (enq_ready_q && bus.enq_valid) begin
            out_words_q <= bus.enq_bits;
            out_tog_q   <= ~out_tog_q;
            out_cnt     <= out_cnt + 16'd1;
            enq_ready_q <= 1'b0;
            out_state   <= E_FULL;
          end else begin
            enq_ready_q <= 1'b1;
          end
        end
        E_FULL: begin
          if (oack_s == out_tog_q) begin
            enq_ready_q <= 1'b1;
            out_state   <= E_EMPTY;
          end
        end
      endcase
    end
  end

  assign bus.deq_valid       = (in_state == I_HOLD);
  assign bus.deq_bits        = deq_bits_q;
  assign bus.host_in_ack     = in_ack_q;
  assign bus.in_count        = in_cnt;
  assign bus.enq_ready       = enq_ready_q;
  assign bus.host_out_words  = out_words_q;
  assign bus.host_out_toggle = out_tog_q;
  assign bus.out_count       = out_cnt;
endmodule

// File: tb/tb_host_decoupled_bridge.sv
// Bench for host_decoupled_bridge: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_host_decoupled_bridge;
  localparam int HW = 16;
  localparam int IW = 2;
  localparam int OW = 1;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  host_decoupled_bridge_if #(.HOST_W(HW), .IN_WORDS(IW), .OUT_WORDS(OW)) bus ();

  host_decoupled_bridge #(.HOST_W(HW), .IN_WORDS(IW), .OUT_WORDS(OW), .SYNC_STAGES(SS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: host toggles seen SS edges late; one pending ingress payload, one egress slot.
  logic          tin_hist [8];
  logic          oack_hist[8];
  int            m_n = 0;
  bit            model_on = 0;
  bit            m_hold, m_ack, m_full, m_otog, m_rdy;
  logic [31:0]   m_deq_bits;
  logic [15:0]   m_out_words;
  logic [15:0]   m_in_cnt, m_out_cnt;

  always @(posedge clock) begin
    logic t_s, a_s;
    if (reset) begin
      m_hold = 0; m_ack = 0; m_full = 0; m_otog = 0; m_rdy = 0;
      m_deq_bits = '0; m_out_words = '0; m_in_cnt = '0; m_out_cnt = '0;
      m_n = 0;
      model_on = 1;
    end else begin
      t_s = (m_n >= SS) ? tin_hist[(m_n - SS) % 8]  : 1'b0;
      a_s = (m_n >= SS) ? oack_hist[(m_n - SS) % 8] : 1'b0;
      tin_hist[m_n % 8]  = bus.host_in_toggle;
      oack_hist[m_n % 8] = bus.host_out_ack;
      if (!m_hold && (t_s != m_ack)) begin
        m_hold = 1;
        m_deq_bits = bus.host_in_words;
      end else if (m_hold && bus.deq_ready) begin
        m_hold = 0;
        m_ack = ~m_ack;
        m_in_cnt = m_in_cnt + 16'd1;
      end
      if (!m_full && m_rdy && bus.enq_valid) begin
        m_full = 1; m_rdy = 0;
        m_out_words = bus.enq_bits;
        m_otog = ~m_otog;
        m_out_cnt = m_out_cnt + 16'd1;
      end else if (m_full && (a_s == m_otog)) begin
        m_full = 0; m_rdy = 1;
      end else if (!m_full) begin
        m_rdy = 1;
      end
      m_n++;
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("deq_valid",       bus.deq_valid,       m_hold);
      chk("deq_bits",        bus.deq_bits,        m_deq_bits);
      chk("host_in_ack",     bus.host_in_ack,     m_ack);
      chk("in_count",        bus.in_count,        m_in_cnt);
      chk("enq_ready",       bus.enq_ready,       m_rdy);
      chk("host_out_words",  bus.host_out_words,  m_out_words);
      chk("host_out_toggle", bus.host_out_toggle, m_otog);
      chk("out_count",       bus.out_count,       m_out_cnt);
    end
  end

  task automatic do_reset();
    bus.host_in_toggle = 1'b0;
    bus.host_out_ack   = 1'b0;
    bus.enq_valid      = 1'b0;
    bus.deq_ready      = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_deq_valid(input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus.deq_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_enq_ready(input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus.enq_ready) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int lat;
    bus.host_in_words  = '0;
    bus.host_in_toggle = 1'b0;
    bus.deq_ready      = 1'b0;
    bus.enq_valid      = 1'b0;
    bus.enq_bits       = '0;
    bus.host_out_ack   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_deq_valid", bus.deq_valid, 0);
    chk("rst_enq_ready", bus.enq_ready, 1);
    chk("rst_in_ack",    bus.host_in_ack, 0);
    chk("rst_out_tog",   bus.host_out_toggle, 0);
    chk("rst_in_count",  bus.in_count, 0);
    chk("rst_out_count", bus.out_count, 0);

    // single commit with ready high
    bus.host_in_words  = 32'hBEEF_1234;
    bus.deq_ready      = 1'b1;
    bus.host_in_toggle = 1'b1;
    wait_deq_valid("lat1", lat);
    chk("ingress_latency", lat, 3);
    chk("deq_bits_1", bus.deq_bits, 32'hBEEF_1234);
    @(negedge clock);
    chk("one_cycle_valid", bus.deq_valid, 0);
    chk("ack_after_1", bus.host_in_ack, 1);
    chk("in_count_1", bus.in_count, 1);
    repeat (4) @(negedge clock);
    chk("no_double_xfer", bus.in_count, 1);

    // commit with ready held low for 10 cycles
    bus.deq_ready      = 1'b0;
    bus.host_in_words  = 32'h1357_9BDF;
    bus.host_in_toggle = 1'b0;
    wait_deq_valid("lat2", lat);
    bus.host_in_words  = 32'h0;
    repeat (10) @(negedge clock);
    chk("stall_valid", bus.deq_valid, 1);
    chk("stall_bits", bus.deq_bits, 32'h1357_9BDF);
    bus.deq_ready = 1'b1;
    @(negedge clock);
    chk("stall_done", bus.in_count, 2);
    chk("stall_ack", bus.host_in_ack, 0);
    bus.host_in_words  = 32'hCAFE_F00D;
    bus.host_in_toggle = 1'b1;
    wait_deq_valid("lat3", lat);
    chk("deq_bits_3", bus.deq_bits, 32'hCAFE_F00D);
    @(negedge clock);
    chk("in_count_3", bus.in_count, 3);

    // egress capture and back-pressure
    do_reset();
    bus.enq_bits  = 16'h00A5;
    bus.enq_valid = 1'b1;
    @(negedge clock);
    chk("egr_words_1", bus.host_out_words, 16'h00A5);
    chk("egr_tog_1", bus.host_out_toggle, 1);
    chk("egr_rdy_1", bus.enq_ready, 0);
    bus.enq_bits = 16'h005A;
    repeat (5) @(negedge clock);
    chk("egr_blocked", bus.host_out_words, 16'h00A5);
    bus.host_out_ack = 1'b1;
    wait_enq_ready("egr1", lat);
    chk("egr_ack_latency", lat, 3);
    @(negedge clock);
    bus.enq_valid = 1'b0;
    chk("egr_words_2", bus.host_out_words, 16'h005A);
    chk("egr_tog_2", bus.host_out_toggle, 0);
    chk("egr_count_2", bus.out_count, 2);
    bus.host_out_ack = 1'b0;
    wait_enq_ready("egr2", lat);
    chk("egr_ack_latency_2", lat, 3);

    // simultaneous ingress transfer and egress capture
    do_reset();
    bus.deq_ready      = 1'b1;
    bus.host_in_words  = 32'h0F0F_A0A0;
    bus.host_in_toggle = 1'b1;
    wait_deq_valid("sim", lat);
    bus.enq_bits  = 16'h1234;
    bus.enq_valid = 1'b1;
    @(negedge clock);
    bus.enq_valid = 1'b0;
    chk("sim_in_count", bus.in_count, 1);
    chk("sim_out_count", bus.out_count, 1);
    chk("sim_out_words", bus.host_out_words, 16'h1234);

    // counter wrap
    do_reset();
    @(posedge clock);
    #1;
    force dut.in_cnt = 16'hFFFF;
    m_in_cnt = 16'hFFFF;
    @(posedge clock);
    #1;
    release dut.in_cnt;
    @(negedge clock);
    chk("preload", bus.in_count, 16'hFFFF);
    bus.deq_ready      = 1'b1;
    bus.host_in_words  = 32'h5555_AAAA;
    bus.host_in_toggle = 1'b1;
    wait_deq_valid("wrap", lat);
    @(negedge clock);
    chk("wrap_count", bus.in_count, 16'h0000);
    chk("wrap_ack", bus.host_in_ack, 1);

    // reset while holding a payload
    bus.deq_ready      = 1'b0;
    bus.host_in_words  = 32'h7777_8888;
    bus.host_in_toggle = 1'b0;
    wait_deq_valid("hold", lat);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_hold_valid", bus.deq_valid, 0);
    chk("rst_hold_ack", bus.host_in_ack, 0);
    chk("rst_hold_count", bus.in_count, 0);
    chk("rst_hold_bits", bus.deq_bits, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
